// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO: drains words into a 3-entry holding buffer
// and presents them as a valid/ready stream with m_last every FRAME_LEN words.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_read,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      frame_cnt
);

  localparam int             BW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(FRAME_LEN - 1);

  logic             pend;
  logic [1:0]       occ;
  logic [1:0]       head;
  logic [1:0]       tail;
  logic [BW-1:0]    beat_cnt;
  logic [WIDTH-1:0] buffer [0:2];

  logic       pop;
  logic       at_last;
  logic [2:0] fill;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    fill      = {1'b0, occ} + {2'b00, pend};
    // Counting the in-flight read keeps the buffer from overflowing without looking at m_ready.
    fifo_read = rst && !fifo_empty && (fill < 3'd3);
    m_valid   = (occ != 2'd0);
    m_data    = m_valid ? buffer[head] : '0;
    at_last   = (beat_cnt == LAST_BEAT);
    m_last    = m_valid && at_last;
    pop       = m_valid && m_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend      <= 1'b0;
      occ       <= 2'd0;
      head      <= 2'd0;
      tail      <= 2'd0;
      beat_cnt  <= '0;
      frame_cnt <= 16'd0;
    end else begin
      pend <= fifo_read;
      occ  <= 2'(fill - {2'b00, pop});
      if (pend) tail <= next_ptr(tail);
      if (pop) begin
        head <= next_ptr(head);
        if (at_last) begin
          beat_cnt  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

  // NOTE: buffer storage has no reset; occ=0 masks stale contents and m_data is gated by m_valid.
  always_ff @(posedge clk) begin
    if (pend) buffer[tail] <= fifo_dout;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO on the read side, scoreboard of expected
// words and frame delimiters filled as words are written into the FIFO.
module tb_fifo_stream_reader;

  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_read;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [15:0]      frame_cnt;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] wr_q[$];

  int checks   = 0;
  int errors   = 0;
  int push_idx = 0;
  int pop_cnt  = 0;
  int rd_cnt   = 0;
  int rd_empty = 0;
  int overread = 0;

  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] held_data  = '0;
  logic             held_last  = 1'b0;
  exp_t             mon_e;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_read  (fifo_read),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .frame_cnt  (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Synchronous FIFO model: writes land at an edge, empty falls after it, dout is registered.
  always @(posedge clk) begin
    if (!rst) begin
      fifo_q.delete();
      wr_q.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_read) begin
        if (fifo_q.size() == 0) overread++;
        else fifo_dout <= fifo_q.pop_front();
      end
      while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (fifo_read) rd_cnt++;
      if (fifo_read && fifo_empty) rd_empty++;
      if (stall_prev) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(held_data));
        check("stall_last", 32'(m_last), 32'(held_last));
      end
      if (m_valid && m_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("data", 32'(m_data), 32'(mon_e.data));
          check("last", 32'(m_last), 32'(mon_e.last));
        end
        pop_cnt++;
      end
      stall_prev = m_valid && !m_ready;
      held_data  = m_data;
      held_last  = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    exp_t e;
    e.data = d;
    e.last = ((push_idx % FRAME_LEN) == FRAME_LEN - 1);
    push_idx++;
    exp_q.push_back(e);
    wr_q.push_back(d);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    push_idx = 0;
    tick();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_frame", 32'(frame_cnt), 32'd0);
    check("rst_read", 32'(fifo_read), 32'd0);
    tick();
    rst = 1'b1;
  endtask

  task automatic drain(input bit toggle, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 300) begin
      m_ready = toggle ? ~m_ready : 1'b1;
      tick();
      n++;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    // Single word: m_valid two cycles after fifo_empty falls, one pulse.
    do_reset();
    m_ready = 1'b1;
    push_word(8'hA5);
    tick();
    check("t1_empty_fell", 32'(fifo_empty), 32'd0);
    n = 0;
    while (!m_valid && n < 10) begin
      tick();
      n++;
    end
    check("t1_latency", 32'(n), 32'd2);
    check("t1_data", 32'(m_data), 32'hA5);
    check("t1_last", 32'(m_last), 32'd0);
    check("t1_frame", 32'(frame_cnt), 32'd0);
    tick();
    check("t1_single_pulse", 32'(m_valid), 32'd0);

    // Streaming: 8 words back to back, two frames.
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    n = 0;
    while (!m_valid && n < 10) begin
      tick();
      n++;
    end
    n = 0;
    while (m_valid && n < 20) begin
      tick();
      n++;
    end
    check("t2_run_len", 32'(n), 32'd8);
    check("t2_frames", 32'(frame_cnt), 32'd2);
    check("t2_left", 32'(exp_q.size()), 32'd0);

    // Backpressure: only three reads while stalled, then full drain in order.
    do_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_word(8'(i));
    base = rd_cnt;
    repeat (10) tick();
    check("t3_reads", 32'(rd_cnt - base), 32'd3);
    check("t3_valid", 32'(m_valid), 32'd1);
    check("t3_read_low", 32'(fifo_read), 32'd0);
    check("t3_fifo_has_rest", 32'(fifo_empty), 32'd0);
    drain(1'b0, "t3_drain");
    check("t3_frames", 32'(frame_cnt), 32'd1);

    // Toggled ready on a 12-word stream.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_word(8'(8'h40 + i * 3));
    drain(1'b1, "t4_drain");
    check("t4_frames", 32'(frame_cnt), 32'd3);

    // Empty gap mid-frame: beat count persists across the gap.
    do_reset();
    m_ready = 1'b1;
    push_word(8'h11);
    push_word(8'h22);
    repeat (9) tick();
    check("t5_gap_idle", 32'(m_valid), 32'd0);
    check("t5_gap_frames", 32'(frame_cnt), 32'd0);
    push_word(8'h33);
    push_word(8'h44);
    drain(1'b0, "t5_drain");
    check("t5_frames", 32'(frame_cnt), 32'd1);

    // Reset mid-frame: remaining words discarded, next frame starts at beat 0.
    do_reset();
    m_ready = 1'b1;
    base = pop_cnt;
    for (int i = 0; i < 4; i++) push_word(8'(8'hB0 + i));
    n = 0;
    while ((pop_cnt - base) < 2 && n < 20) begin
      tick();
      n++;
    end
    check("t6_two_pops", 32'(pop_cnt - base), 32'd2);
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'(8'hC1 + i));
    drain(1'b0, "t6_drain");
    check("t6_frames", 32'(frame_cnt), 32'd1);

    check("rd_while_empty", 32'(rd_empty), 32'd0);
    check("over_read", 32'(overread), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
